fifo_wr_arb: RTL and testbench
==============================

FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 Parameter N_REQ, default 4, is the number of requesters sharing the FIFO write port (2..8).
REQ-002 Parameter DATA_W, default 8, is the FIFO data word width.
REQ-003 Parameter TMO, default 16, is the idle-cycle limit while a packet is locked (>=2).
REQ-004 clk  input  1  is the single clock; all state changes on posedge clk.
REQ-005 rst_n  input  1  is the asynchronous active-low reset.
REQ-006 req_valid  input  N_REQ  is the per-requester word-valid signal.
REQ-007 req_data  input  N_REQ*DATA_W  is the per-requester word; requester i occupies bits [i*DATA_W +: DATA_W].
REQ-008 req_last  input  N_REQ  marks the final word of a packet.
REQ-009 req_ready  output  N_REQ  is the per-requester accept signal.
REQ-010 fifo_full  input  1  is the FIFO full status from the write-side pointer.
REQ-011 fifo_wr_en  output  1  is the FIFO write enable.
REQ-012 fifo_wr_data  output  DATA_W  is the FIFO write data.
REQ-013 grant_id  output  $clog2(N_REQ)  is the currently selected requester.
REQ-014 busy  output  1  is high while a packet is locked.
REQ-015 tmo_err  output  1  is a one-cycle pulse on packet-lock timeout.

Function
REQ-016 The block SHALL have two states, IDLE and LOCK, plus registers rr_ptr, owner and idle_cnt.
REQ-017 In IDLE, sel SHALL be the first requester with req_valid=1, searching circularly from rr_ptr upward; if none is valid, sel=rr_ptr.
REQ-018 In LOCK, sel SHALL equal owner, regardless of other valids.
REQ-019 req_ready[i] SHALL be (i==sel) & !fifo_full; all other bits SHALL be 0.
REQ-020 A transfer SHALL occur when req_valid[sel] & req_ready[sel]; fifo_wr_en SHALL equal transfer in the same cycle (zero latency).
REQ-021 fifo_wr_data SHALL be req_data of sel, combinationally.
REQ-022 IDLE, transfer with req_last=1: stay in IDLE; rr_ptr <= sel+1 modulo N_REQ.
REQ-023 IDLE, transfer with req_last=0: go to LOCK; owner <= sel; idle_cnt <= 0.
REQ-024 LOCK, transfer with req_last=1: go to IDLE; rr_ptr <= owner+1 modulo N_REQ.
REQ-025 LOCK, transfer with req_last=0: idle_cnt <= 0.
REQ-026 LOCK with no transfer and req_valid[owner]=0: idle_cnt increments.
REQ-027 When idle_cnt reaches TMO-1 with no transfer, the next edge SHALL go to IDLE, set rr_ptr <= owner+1, and pulse tmo_err for exactly one cycle.
REQ-028 LOCK with no transfer because fifo_full=1 while req_valid[owner]=1: idle_cnt SHALL hold, and no timeout SHALL occur.
REQ-029 While fifo_full=1, fifo_wr_en SHALL be 0 and state, rr_ptr and owner SHALL hold.
REQ-030 If fifo_full and the packet end coincide, the last word SHALL NOT transfer until fifo_full drops.
REQ-031 grant_id SHALL equal sel; busy SHALL equal (state==LOCK).
REQ-032 rr_ptr+1 and owner+1 SHALL wrap from N_REQ-1 to 0, including for non-power-of-two N_REQ.

Reset
REQ-033 While rst_n=0, the block SHALL asynchronously hold state=IDLE, rr_ptr=0, owner=0, idle_cnt=0 and tmo_err=0; consequently busy=0, and grant_id=0 when no valid is asserted.
REQ-034 Reset asserted mid-packet SHALL abandon the lock without pulsing tmo_err; the first edge after release SHALL arbitrate from rr_ptr=0.

Structure
REQ-035 A shared package fifo_pkg SHALL hold ptr_w, the IDLE/LOCK state enum and the default DATA_W.
REQ-036 The circular priority search SHALL be a combinational sub-module rr_pick (inputs: valid vector and start index; output: winner index).

Verification
REQ-037 N_REQ=4; req_valid=4'b1111, all words last=1, fifo_full=0 -> grants in order 0,1,2,3,0 on consecutive cycles, fifo_wr_en=1 on each.
REQ-038 Requester 2 sends a 3-word packet 0xA1,0xA2,0xA3 while requester 0 stays valid -> FIFO receives A1,A2,A3 contiguously, busy=1 for 2 cycles, then requester 0 is granted.
REQ-039 fifo_full=1 for 5 cycles in mid-packet -> fifo_wr_en=0 and req_ready=0, no tmo_err; the packet resumes intact when fifo_full drops.
REQ-040 Owner drops req_valid after its first word, TMO=16 -> tmo_err pulses once 16 cycles later, busy falls, and the next requester is granted.
REQ-041 rst_n asserted low for 1 cycle mid-packet -> busy=0 immediately, no tmo_err, and the next grant goes to the lowest valid index.
REQ-042 N_REQ=3, only requester 2 valid with last=1 -> grant 2, then rr_ptr wraps to 0.

Source files
------------

// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared types and helpers for the FIFO write-port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    localparam int DATA_W_DEF = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    // Index width for n requesters, never narrower than one bit.
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Circular first-valid search starting at a given index.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import fifo_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int PTR_W = ptr_w(N_REQ)
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [PTR_W-1:0] start,
    output logic [PTR_W-1:0] winner
);

    logic [PTR_W-1:0] w_idx;

    // Walk from the farthest offset back to the start so the nearest valid wins.
    always_comb begin
        winner = start;
        w_idx  = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_idx = PTR_W'((int'(start) + k) % N_REQ);
            if (valid[w_idx]) begin
                winner = w_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fifo_wr_arb.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_arb
// Description : Round-robin packet arbiter for a shared FIFO write port.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_arb
    import fifo_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int DATA_W = DATA_W_DEF,
    parameter int TMO    = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*DATA_W-1:0]  req_data,
    input  logic [N_REQ-1:0]         req_last,
    output logic [N_REQ-1:0]         req_ready,
    input  logic                     fifo_full,
    output logic                     fifo_wr_en,
    output logic [DATA_W-1:0]        fifo_wr_data,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     busy,
    output logic                     tmo_err
);

    localparam int                 c_PTR_W    = ptr_w(N_REQ);
    localparam int                 c_CNT_W    = $clog2(TMO);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX  = c_CNT_W'(TMO - 1);
    localparam logic [c_PTR_W-1:0] c_LAST_IDX = c_PTR_W'(N_REQ - 1);

    arb_state_t         r_state, w_state_nxt;
    logic [c_PTR_W-1:0] r_rr_ptr, w_rr_ptr_nxt;
    logic [c_PTR_W-1:0] r_owner, w_owner_nxt;
    logic [c_CNT_W-1:0] r_idle_cnt, w_idle_cnt_nxt;
    logic               r_tmo_err, w_tmo_nxt;
    logic [c_PTR_W-1:0] w_pick, w_sel;
    logic               w_xfer;

    function automatic logic [c_PTR_W-1:0] inc_wrap(input logic [c_PTR_W-1:0] p);
        return (p == c_LAST_IDX) ? '0 : p + c_PTR_W'(1);
    endfunction

    rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (c_PTR_W)
    ) u_rr_pick (
        .valid  (req_valid),
        .start  (r_rr_ptr),
        .winner (w_pick)
    );

    always_comb begin
        w_sel            = (r_state == LOCK) ? r_owner : w_pick;
        w_xfer           = req_valid[w_sel] & ~fifo_full;
        req_ready        = '0;
        req_ready[w_sel] = ~fifo_full;
        fifo_wr_en       = w_xfer;
        fifo_wr_data     = req_data[int'(w_sel)*DATA_W +: DATA_W];
        grant_id         = w_sel;
        busy             = (r_state == LOCK);

        w_state_nxt    = r_state;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_owner_nxt    = r_owner;
        w_idle_cnt_nxt = r_idle_cnt;
        w_tmo_nxt      = 1'b0;

        if (w_xfer) begin
            if (req_last[w_sel]) begin
                w_state_nxt  = IDLE;
                w_rr_ptr_nxt = inc_wrap(w_sel);
            end else begin
                w_state_nxt    = LOCK;
                w_owner_nxt    = w_sel;
                w_idle_cnt_nxt = '0;
            end
        end else if ((r_state == LOCK) && !req_valid[r_owner]) begin
            // Count saturates while the FIFO is full; the timeout fires once it drains.
            if (r_idle_cnt != c_CNT_MAX) begin
                w_idle_cnt_nxt = r_idle_cnt + c_CNT_W'(1);
            end else if (!fifo_full) begin
                w_state_nxt  = IDLE;
                w_rr_ptr_nxt = inc_wrap(r_owner);
                w_tmo_nxt    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_rr_ptr   <= '0;
            r_owner    <= '0;
            r_idle_cnt <= '0;
            r_tmo_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_owner    <= w_owner_nxt;
            r_idle_cnt <= w_idle_cnt_nxt;
            r_tmo_err  <= w_tmo_nxt;
        end
    end

    assign tmo_err = r_tmo_err;

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_wr_arb
// Description : Self-checking bench for fifo_wr_arb (4- and 3-requester builds).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arb;

    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  req_valid, req_last, req_ready;
    logic [N*DW-1:0] req_data;
    logic          fifo_full, fifo_wr_en, busy, tmo_err;
    logic [DW-1:0] fifo_wr_data;
    logic [1:0]    grant_id;

    logic [2:0]    v3, l3, r3;
    logic [23:0]   d3;
    logic          f3, we3, b3, t3;
    logic [7:0]    wd3;
    logic [1:0]    g3;

    int n_pass = 0;
    int n_chk  = 0;

    always #5 clk = ~clk;

    fifo_wr_arb #(.N_REQ(N), .DATA_W(DW), .TMO(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .fifo_full(fifo_full),
        .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .grant_id(grant_id),
        .busy(busy), .tmo_err(tmo_err)
    );

    fifo_wr_arb #(.N_REQ(3), .DATA_W(8), .TMO(TMO)) dut3 (
        .clk(clk), .rst_n(rst_n), .req_valid(v3), .req_data(d3),
        .req_last(l3), .req_ready(r3), .fifo_full(f3),
        .fifo_wr_en(we3), .fifo_wr_data(wd3), .grant_id(g3),
        .busy(b3), .tmo_err(t3)
    );

    typedef struct {
        logic [N-1:0] v;
        logic [N-1:0] l;
        logic         f;
        int           g;
        logic         wr;
        logic         bz;
    } vec_t;

    vec_t tbl[14];

    // reference model state
    bit m_locked;
    int m_owner, m_rr, m_idle;
    bit m_tmo;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic chk_outs(input string tag, input int g, input logic wr, input logic bz,
                            input logic te, input logic [7:0] dat);
        logic [N-1:0] rdy;
        rdy = '0;
        if (!fifo_full) rdy[g] = 1'b1;
        chk({tag, ".grant"}, 32'(grant_id), 32'(g));
        chk({tag, ".wr_en"}, 32'(fifo_wr_en), 32'(wr));
        chk({tag, ".ready"}, 32'(req_ready), 32'(rdy));
        chk({tag, ".busy"}, 32'(busy), 32'(bz));
        chk({tag, ".tmo"}, 32'(tmo_err), 32'(te));
        if (wr) chk({tag, ".data"}, 32'(fifo_wr_data), 32'(dat));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic [N-1:0] v, input logic [N-1:0] l, input logic f);
        req_valid = v;
        req_last  = l;
        fifo_full = f;
        #1;
    endtask

    task automatic setw(input int i, input logic [7:0] w);
        req_data[i*DW +: DW] = w;
    endtask

    task automatic do_reset();
        req_valid = '0; req_last = '0; fifo_full = 1'b0;
        req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
        v3 = '0; l3 = '0; f3 = 1'b0; d3 = {8'h32, 8'h31, 8'h30};
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{4'b0000, 4'b0000, 1'b0, 0, 1'b0, 1'b0};
        tbl[1]  = '{4'b1111, 4'b1111, 1'b0, 0, 1'b1, 1'b0};
        tbl[2]  = '{4'b1111, 4'b1111, 1'b0, 1, 1'b1, 1'b0};
        tbl[3]  = '{4'b1111, 4'b1111, 1'b0, 2, 1'b1, 1'b0};
        tbl[4]  = '{4'b1111, 4'b1111, 1'b0, 3, 1'b1, 1'b0};
        tbl[5]  = '{4'b1111, 4'b1111, 1'b0, 0, 1'b1, 1'b0};
        tbl[6]  = '{4'b0100, 4'b0000, 1'b0, 2, 1'b1, 1'b0};
        tbl[7]  = '{4'b1111, 4'b0000, 1'b1, 2, 1'b0, 1'b1};
        tbl[8]  = '{4'b0101, 4'b0100, 1'b0, 2, 1'b1, 1'b1};
        tbl[9]  = '{4'b0011, 4'b0011, 1'b0, 0, 1'b1, 1'b0};
        tbl[10] = '{4'b0000, 4'b0000, 1'b0, 1, 1'b0, 1'b0};
        tbl[11] = '{4'b1000, 4'b1000, 1'b1, 3, 1'b0, 1'b0};
        tbl[12] = '{4'b1000, 4'b1000, 1'b0, 3, 1'b1, 1'b0};
        tbl[13] = '{4'b0000, 4'b0000, 1'b0, 0, 1'b0, 1'b0};

        // ---------------- table vectors ----------------
        do_reset();
        chk("dut3.reset.busy", 32'(b3), 32'd0);
        chk("dut3.reset.grant", 32'(g3), 32'd0);
        for (int i = 0; i < 14; i++) begin
            drv(tbl[i].v, tbl[i].l, tbl[i].f);
            chk_outs($sformatf("vec%0d", i), tbl[i].g, tbl[i].wr, tbl[i].bz, 1'b0,
                     8'(8'h10 + tbl[i].g));
            tick();
        end

        // ---------------- locked packet with competitor ----------------
        do_reset();
        drv(4'b0010, 4'b0010, 1'b0); chk_outs("pkt.pre", 1, 1'b1, 1'b0, 1'b0, 8'h11); tick();
        setw(2, 8'hA1); drv(4'b0101, 4'b0000, 1'b0); chk_outs("pkt.a1", 2, 1'b1, 1'b0, 1'b0, 8'hA1); tick();
        setw(2, 8'hA2); drv(4'b0101, 4'b0000, 1'b0); chk_outs("pkt.a2", 2, 1'b1, 1'b1, 1'b0, 8'hA2); tick();
        setw(2, 8'hA3); drv(4'b0101, 4'b0100, 1'b0); chk_outs("pkt.a3", 2, 1'b1, 1'b1, 1'b0, 8'hA3); tick();
        drv(4'b0001, 4'b0001, 1'b0); chk_outs("pkt.next", 0, 1'b1, 1'b0, 1'b0, 8'h10); tick();

        // ---------------- FIFO full mid-packet ----------------
        do_reset();
        drv(4'b0010, 4'b0010, 1'b0); tick();
        setw(2, 8'hA1); drv(4'b0101, 4'b0000, 1'b0); chk_outs("full.a1", 2, 1'b1, 1'b0, 1'b0, 8'hA1); tick();
        setw(2, 8'hA2);
        for (int k = 0; k < 20; k++) begin
            drv(4'b0101, 4'b0000, 1'b1);
            chk_outs($sformatf("full.hold%0d", k), 2, 1'b0, 1'b1, 1'b0, 8'h00);
            tick();
        end
        drv(4'b0101, 4'b0000, 1'b0); chk_outs("full.a2", 2, 1'b1, 1'b1, 1'b0, 8'hA2); tick();
        setw(2, 8'hA3); drv(4'b0101, 4'b0100, 1'b0); chk_outs("full.a3", 2, 1'b1, 1'b1, 1'b0, 8'hA3); tick();
        drv(4'b0001, 4'b0001, 1'b0); chk_outs("full.next", 0, 1'b1, 1'b0, 1'b0, 8'h10); tick();

        // ---------------- lock timeout ----------------
        do_reset();
        drv(4'b0001, 4'b0000, 1'b0); chk_outs("tmo.first", 0, 1'b1, 1'b0, 1'b0, 8'h10); tick();
        for (int k = 0; k < TMO; k++) begin
            drv(4'b0010, 4'b0010, 1'b0);
            chk_outs($sformatf("tmo.wait%0d", k), 0, 1'b0, 1'b1, 1'b0, 8'h00);
            tick();
        end
        drv(4'b0010, 4'b0010, 1'b0); chk_outs("tmo.pulse", 1, 1'b1, 1'b0, 1'b1, 8'h11); tick();
        drv(4'b0010, 4'b0010, 1'b0); chk_outs("tmo.after", 1, 1'b1, 1'b0, 1'b0, 8'h11); tick();

        // ---------------- reset mid-packet ----------------
        do_reset();
        drv(4'b0010, 4'b0010, 1'b0); tick();
        drv(4'b0100, 4'b0000, 1'b0); chk_outs("rst.lock", 2, 1'b1, 1'b0, 1'b0, 8'h12); tick();
        chk("rst.busy_before", 32'(busy), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst.busy_async", 32'(busy), 32'd0);
        chk("rst.tmo_async", 32'(tmo_err), 32'd0);
        tick();
        rst_n = 1'b1;
        drv(4'b1110, 4'b1110, 1'b0); chk_outs("rst.first", 1, 1'b1, 1'b0, 1'b0, 8'h11); tick();
        drv(4'b1110, 4'b1110, 1'b0); chk_outs("rst.second", 2, 1'b1, 1'b0, 1'b0, 8'h12); tick();

        // ---------------- N_REQ=3 wrap ----------------
        do_reset();
        v3 = 3'b100; l3 = 3'b100; #1;
        chk("n3.g2", 32'(g3), 32'd2); chk("n3.we", 32'(we3), 32'd1); chk("n3.data", 32'(wd3), 32'h32);
        tick();
        v3 = 3'b111; l3 = 3'b111; #1;
        chk("n3.wrap_rr", 32'(g3), 32'd0);
        tick();
        v3 = 3'b100; l3 = 3'b000; #1;
        chk("n3.lock_g", 32'(g3), 32'd2);
        tick();
        v3 = 3'b111; l3 = 3'b100; #1;
        chk("n3.lock_busy", 32'(b3), 32'd1); chk("n3.lock_end", 32'(g3), 32'd2);
        tick();
        v3 = 3'b111; l3 = 3'b111; #1;
        chk("n3.wrap_owner", 32'(g3), 32'd0); chk("n3.idle", 32'(b3), 32'd0);
        tick();

        // ---------------- randomized vs reference model ----------------
        do_reset();
        m_locked = 1'b0; m_owner = 0; m_rr = 0; m_idle = 0; m_tmo = 1'b0;
        for (int seg = 0; seg < 10; seg++) begin
            int pv, pf;
            pv = (seg % 3 == 0) ? 10 : ((seg % 3 == 1) ? 50 : 90);
            pf = (seg % 4 == 0) ? 0 : ((seg % 4 == 1) ? 20 : ((seg % 4 == 2) ? 60 : 5));
            for (int c = 0; c < 200; c++) begin
                int  sel;
                bit  xf;
                logic [N-1:0] v, l;
                for (int i = 0; i < N; i++) begin
                    v[i] = ($urandom_range(99) < pv);
                    l[i] = ($urandom_range(2) == 0);
                end
                req_data = $urandom;
                drv(v, l, ($urandom_range(99) < pf));

                if (m_locked) sel = m_owner;
                else begin
                    sel = m_rr;
                    for (int k = 0; k < N; k++) begin
                        if (req_valid[(m_rr + k) % N]) begin
                            sel = (m_rr + k) % N;
                            break;
                        end
                    end
                end
                xf = req_valid[sel] && !fifo_full;
                chk_outs("rnd", sel, xf, m_locked, m_tmo, req_data[sel*DW +: DW]);

                m_tmo = 1'b0;
                if (xf) begin
                    if (req_last[sel]) begin
                        m_locked = 1'b0;
                        m_rr = (sel + 1) % N;
                    end else begin
                        m_locked = 1'b1;
                        m_owner = sel;
                        m_idle = 0;
                    end
                end else if (m_locked && !req_valid[m_owner]) begin
                    if (m_idle < TMO - 1) m_idle++;
                    else if (!fifo_full) begin
                        m_locked = 1'b0;
                        m_rr = (m_owner + 1) % N;
                        m_tmo = 1'b1;
                    end
                end
                tick();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
